// File: rtl/fpga_mailbox_pkg.sv
// rtl/fpga_mailbox_pkg.sv - offsets, constants and FSM states for the OBI mailbox
package fpga_mailbox_pkg;

  // The bus masks the region base, so only this many low byte-address bits are decoded.
  localparam int unsigned DEC_BITS  = 12;
  localparam int unsigned WORD_BITS = DEC_BITS - 2;

  localparam logic [DEC_BITS-1:0] STATUS_OFF   = 12'h000;
  localparam logic [DEC_BITS-1:0] LED_OFF      = 12'h004;
  localparam logic [DEC_BITS-1:0] DOORBELL_OFF = 12'h008;
  localparam logic [DEC_BITS-1:0] SCRATCH_OFF  = 12'h00C;

  localparam logic [31:0] BAD_RDATA = 32'hBADCAB1E;

  typedef enum logic {IDLE, WAIT} state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpga_mailbox_regfile.sv
// rtl/fpga_mailbox_regfile.sv - scratch word array with byte-enable write and registered read
module fpga_mailbox_regfile
  import fpga_mailbox_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_WORDS];

  // rdata is zero except in the cycle after a read, so the top can OR it into the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) mem[k] <= '0;
      rdata <= '0;
    end else begin
      rdata <= rd_en ? mem[idx] : '0;
      if (wr_en) mem[idx] <= be_merge(mem[idx], wdata, be);
    end
  end

endmodule

// File: rtl/fpga_obi_mailbox_responder.sv
// rtl/fpga_obi_mailbox_responder.sv - OBI responder with STATUS/LED/DOORBELL registers and scratch RAM
module fpga_obi_mailbox_responder
  import fpga_mailbox_pkg::*;
#(
  parameter int unsigned NUM_SCRATCH = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned LED_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_addr_i,
  input  logic [31:0]          obi_wdata_i,
  output logic                 obi_gnt_o,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  output logic [LED_WIDTH-1:0] led_o,
  output logic                 irq_o
);

  localparam int unsigned WCW   = $clog2(WAIT_CYCLES + 2);
  localparam int unsigned IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [WORD_BITS-1:0] SCRATCH_W = SCRATCH_OFF[DEC_BITS-1:2];

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           gnt;
  logic           accept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (obi_req_i) begin
          if (WAIT_CYCLES == 0) begin
            gnt = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WCW'(1);
          end
        end
      end
      WAIT: begin
        // A dropped req here is a master protocol violation; abandon it without committing.
        if (!obi_req_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(WAIT_CYCLES)) begin
          gnt        = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign obi_gnt_o = gnt & ~rst_i;
  assign accept    = obi_req_i & gnt;

  logic [WORD_BITS-1:0] word;
  logic [WORD_BITS-1:0] scr_off;
  logic                 is_status, is_led, is_door, is_scr, is_oor;

  assign word      = obi_addr_i[DEC_BITS-1:2];
  assign scr_off   = word - SCRATCH_W;
  assign is_status = (word == STATUS_OFF[DEC_BITS-1:2]);
  assign is_led    = (word == LED_OFF[DEC_BITS-1:2]);
  assign is_door   = (word == DOORBELL_OFF[DEC_BITS-1:2]);
  assign is_scr    = (32'(scr_off) < NUM_SCRATCH);
  assign is_oor    = !(is_status || is_led || is_door || is_scr);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_addr_i[31:DEC_BITS], obi_addr_i[1:0]};

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 irq_q;
  logic [15:0]          err_cnt_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q, rd_val, scr_rdata;

  always_comb begin
    rd_val = '0;
    if (is_status)    rd_val = {15'b0, irq_q, err_cnt_q};
    else if (is_led)  rd_val = 32'(led_q);
    else if (is_door) rd_val = {31'b0, irq_q};
    else if (is_oor)  rd_val = BAD_RDATA;
  end

  always_comb begin
    led_d = led_q;
    for (int b = 0; b < LED_WIDTH; b++) begin
      if (obi_be_i[b/8]) led_d[b] = obi_wdata_i[b];
    end
  end

  // Read data comes from register values before any write in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q     <= '0;
      irq_q     <= 1'b0;
      err_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= accept;
      rdata_q  <= (accept && !obi_we_i && !is_scr) ? rd_val : '0;
      if (accept && obi_we_i) begin
        if (is_led) led_q <= led_d;
        if (is_door) begin
          if (obi_wdata_i[1])      irq_q <= 1'b0;
          else if (obi_wdata_i[0]) irq_q <= 1'b1;
        end
      end
      if (accept && is_oor && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  fpga_mailbox_regfile #(
    .NUM_WORDS(NUM_SCRATCH),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk  (clk_i),
    .rst  (rst_i),
    .wr_en(accept & obi_we_i & is_scr),
    .rd_en(accept & ~obi_we_i & is_scr),
    .be   (obi_be_i),
    .idx  (scr_off[IDX_W-1:0]),
    .wdata(obi_wdata_i),
    .rdata(scr_rdata)
  );

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q | scr_rdata;
  assign led_o        = led_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_fpga_obi_mailbox_responder.sv
// tb/tb_fpga_obi_mailbox_responder.sv - randomized and directed bench for the OBI mailbox responder
module tb_fpga_obi_mailbox_responder;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req, we, gnt, rvalid, irq;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][7:0]  led;

  always #5 clk = ~clk;

  fpga_obi_mailbox_responder #(.NUM_SCRATCH(16), .WAIT_CYCLES(0), .LED_WIDTH(8)) u0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[0]), .obi_we_i(we[0]), .obi_be_i(be[0]),
    .obi_addr_i(addr[0]), .obi_wdata_i(wdata[0]), .obi_gnt_o(gnt[0]), .obi_rvalid_o(rvalid[0]),
    .obi_rdata_o(rdata[0]), .led_o(led[0]), .irq_o(irq[0]));

  fpga_obi_mailbox_responder #(.NUM_SCRATCH(16), .WAIT_CYCLES(3), .LED_WIDTH(8)) u1 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[1]), .obi_we_i(we[1]), .obi_be_i(be[1]),
    .obi_addr_i(addr[1]), .obi_wdata_i(wdata[1]), .obi_gnt_o(gnt[1]), .obi_rvalid_o(rvalid[1]),
    .obi_rdata_o(rdata[1]), .led_o(led[1]), .irq_o(irq[1]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit abort = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 50) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: register file contents plus "cycles req has been held" per instance.
  logic [31:0] m_scr [2][16];
  logic [7:0]  m_led [2];
  bit          m_irq [2];
  logic [15:0] m_err [2];
  int          held  [2];
  bit          e_rv  [2];
  logic [31:0] e_rd  [2];
  logic [31:0] capq [$];
  int          capc [$];
  bit          cap_en = 0;

  function automatic int wc(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic model_reset(input int i);
    for (int k = 0; k < 16; k++) m_scr[i][k] = '0;
    m_led[i] = '0; m_irq[i] = 0; m_err[i] = '0;
    held[i] = 0; e_rv[i] = 0; e_rd[i] = '0;
  endtask

  task automatic model_access(input int i, input bit wr, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rv);
    int w;
    w  = int'(a[11:2]);
    rv = 32'h0;
    if (w == 0) rv = {15'b0, m_irq[i], m_err[i]};
    else if (w == 1) begin
      rv = {24'b0, m_led[i]};
      if (wr && b[0]) m_led[i] = wd[7:0];
    end else if (w == 2) begin
      rv = {31'b0, m_irq[i]};
      if (wr) m_irq[i] = wd[1] ? 1'b0 : (wd[0] ? 1'b1 : m_irq[i]);
    end else if (w >= 3 && w < 19) begin
      rv = m_scr[i][w-3];
      if (wr) for (int k = 0; k < 4; k++) if (b[k]) m_scr[i][w-3][8*k +: 8] = wd[8*k +: 8];
    end else begin
      rv = 32'hBADCAB1E;
      if (m_err[i] != 16'hFFFF) m_err[i] = m_err[i] + 16'd1;
    end
    if (wr) rv = 32'h0;
  endtask

  always @(negedge clk) begin
    int hn;
    bit eg;
    logic [31:0] rv;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_gnt", gnt[i], 0);
        chk("rst_rvalid", rvalid[i], 0);
        chk("rst_rdata", rdata[i], 0);
        chk("rst_led", led[i], 0);
        chk("rst_irq", irq[i], 0);
        model_reset(i);
      end else begin
        hn = req[i] ? held[i] + 1 : 0;
        eg = req[i] && (hn == wc(i) + 1);
        chk("gnt", gnt[i], eg);
        chk("rvalid", rvalid[i], e_rv[i]);
        chk("rdata", rdata[i], e_rd[i]);
        chk("led", led[i], m_led[i]);
        chk("irq", irq[i], m_irq[i]);
        if (i == 0 && cap_en && rvalid[0]) begin
          capq.push_back(rdata[0]);
          capc.push_back(cyc);
        end
        e_rv[i] = eg;
        e_rd[i] = '0;
        if (eg) begin
          model_access(i, we[i], be[i], addr[i], wdata[i], rv);
          e_rd[i] = rv;
        end
        held[i] = eg ? 0 : hn;
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic xfer(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output int waited);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    waited = 0;
    forever begin
      @(negedge clk);
      if (gnt[i]) break;
      waited++;
      if (waited > 20) begin
        chk("gnt_timeout", 0, 1);
        abort = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int wt;
    xfer(i, 1'b1, b, a, d, wt);
  endtask

  task automatic rd(input int i, input logic [31:0] a, output logic [31:0] d);
    int wt;
    xfer(i, 1'b0, 4'hF, a, 32'h0, wt);
    @(negedge clk);
    chk("rd_rvalid", rvalid[i], 1);
    d = rdata[i];
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int i, input int n);
    logic [31:0] a, d;
    logic [9:0]  w;
    logic [3:0]  b;
    bit          wbit;
    int          wt, sel;
    for (int t = 0; t < n && !abort; t++) begin
      sel = int'($urandom_range(0, 24));
      if (sel < 22) w = 10'(sel);
      else w = 10'($urandom_range(22, 1023));
      a = $urandom;
      a[11:2] = w;
      d = $urandom;
      b = 4'($urandom);
      wbit = 1'($urandom);
      if (i == 1 && $urandom_range(0, 7) == 0) begin
        req[1] = 1'b1; we[1] = wbit; be[1] = b; addr[1] = a; wdata[1] = d;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1 req[1] = 1'b0;
      end else begin
        xfer(i, wbit, b, a, d, wt);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] bb_vals [4] = '{32'hC0DE0001, 32'h12345678, 32'h5A5A0003, 32'hFFFF0004};

  initial begin
    logic [31:0] d;
    int wt;
    rst = 1'b1;
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt0", gnt[0], 0);
    chk("reset_led0", led[0], 0);
    chk("reset_irq0", irq[0], 0);
    rst = 1'b0;

    rd(0, 32'h0000_0000, d);
    chk("status_after_reset", d, 32'h0);

    wr(0, 32'h0000_000C, 32'hDEADBEEF, 4'b0101);
    rd(0, 32'h0000_000C, d);
    chk("scratch0_be_masked", d, 32'h00AD00EF);
    rd(0, 32'h0000_0010, d);
    chk("scratch1_zero", d, 32'h0);

    wr(0, 32'h0000_0004, 32'h0000_00A5, 4'hF);
    chk("led_a5", led[0], 8'hA5);
    wr(0, 32'h0000_0008, 32'h1, 4'hF);
    chk("doorbell_set_irq", irq[0], 1);
    rd(0, 32'h0000_0000, d);
    chk("status_irq_bit", d, 32'h0001_0000);
    wr(0, 32'h0000_0008, 32'h3, 4'hF);
    chk("doorbell_clear_wins", irq[0], 0);

    rd(0, 32'h0000_03FC, d);
    chk("oor_rdata", d, 32'hBADCAB1E);
    rd(0, 32'h0000_0000, d);
    chk("status_err_cnt_1", d, 32'h0000_0001);

    cap_en = 1;
    for (int k = 0; k < 4; k++) xfer(0, 1'b1, 4'hF, 32'h10 + 4 * k, bb_vals[k], wt);
    for (int k = 0; k < 4; k++) xfer(0, 1'b0, 4'hF, 32'h10 + 4 * k, 32'h0, wt);
    repeat (2) @(posedge clk);
    #1 cap_en = 0;
    chk("b2b_count", capq.size(), 8);
    if (capq.size() == 8) begin
      chk("b2b_spacing", capc[7] - capc[0], 7);
      for (int k = 0; k < 4; k++) begin
        chk("b2b_wr_rdata", capq[k], 32'h0);
        chk("b2b_rd_rdata", capq[4+k], bb_vals[k]);
      end
    end

    xfer(1, 1'b0, 4'hF, 32'h0000_0004, 32'h0, wt);
    chk("wait3_gnt_cycle", wt, 3);
    @(negedge clk);
    chk("wait3_rvalid_next", rvalid[1], 1);
    @(posedge clk); #1;

    rand_phase(0, 400);
    rand_phase(1, 300);

    for (int n = 0; n < 70000 && !abort && m_err[0] < 16'hFFFE; n++)
      xfer(0, 1'b0, 4'hF, 32'h0000_0FF0, 32'h0, wt);
    wr(0, 32'h0000_0800, 32'h1, 4'hF);
    rd(0, 32'h0000_0FFC, d);
    rd(0, 32'h0000_0000, d);
    chk("err_cnt_saturated", d[15:0], 16'hFFFF);

    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h0000_000C; wdata[0] = 32'h12345678;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt_dropped", gnt[0], 0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_no_rvalid", rvalid[0], 0);
    rd(0, 32'h0000_000C, d);
    chk("midrst_scratch0", d, 32'h0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
